// File: rtl/attn_tile_seq_if.sv
// Sequencer <-> SA / softmax / write-back handshake and tile coordinates.
// Widths follow the tiling parameters; keep them equal to the sequencer's.
interface attn_tile_seq_if #(
  parameter int SA_R    = 16,
  parameter int SA_C    = 16,
  parameter int SEQ_LEN = 32,
  parameter int D_K     = 128,
  parameter int H_NUM   = 2
);
  localparam int RT = SEQ_LEN / SA_R;
  localparam int CT = D_K / SA_C;
  localparam int RW = (SA_R > 1) ? $clog2(SA_R) : 1;
  localparam int HW = (H_NUM > 1) ? $clog2(H_NUM) : 1;
  localparam int TW = (RT > 1) ? $clog2(RT) : 1;
  localparam int CW = (CT > 1) ? $clog2(CT) : 1;

  logic          I_ATTN_START;
  logic          I_SA_VLD;
  logic          I_SM_VLD;
  logic          O_SA_START;
  logic [1:0]    O_SA_OP;
  logic [7:0]    O_SCALE_VAL;
  logic          O_SM_START;
  logic [RW-1:0] O_SM_ROW;
  logic [7:0]    O_SM_SHIFT;
  logic [HW-1:0] O_HEAD;
  logic [TW-1:0] O_ROW_TILE;
  logic [CW-1:0] O_COL_TILE;
  logic          O_WR_EN;
  logic [HW-1:0] O_WR_HEAD;
  logic [TW-1:0] O_WR_ROW_TILE;
  logic [CW-1:0] O_WR_COL_TILE;
  logic          O_BUSY;
  logic          O_DONE;
  logic          O_PROTO_ERR;
  logic [31:0]   O_CYCLE_CNT;

  modport master (
    input  I_ATTN_START, I_SA_VLD, I_SM_VLD,
    output O_SA_START, O_SA_OP, O_SCALE_VAL,
    output O_SM_START, O_SM_ROW, O_SM_SHIFT,
    output O_HEAD, O_ROW_TILE, O_COL_TILE,
    output O_WR_EN, O_WR_HEAD,
    output O_WR_ROW_TILE, O_WR_COL_TILE,
    output O_BUSY, O_DONE, O_PROTO_ERR,
    output O_CYCLE_CNT
  );

  modport slave (
    output I_ATTN_START, I_SA_VLD, I_SM_VLD,
    input  O_SA_START, O_SA_OP, O_SCALE_VAL,
    input  O_SM_START, O_SM_ROW, O_SM_SHIFT,
    input  O_HEAD, O_ROW_TILE, O_COL_TILE,
    input  O_WR_EN, O_WR_HEAD,
    input  O_WR_ROW_TILE, O_WR_COL_TILE,
    input  O_BUSY, O_DONE, O_PROTO_ERR,
    input  O_CYCLE_CNT
  );
endinterface

// File: rtl/attn_tile_seq.sv
// Tiled multi-head attention sequencer: QK, SCALE, softmax rows, PV tiles.
// ATTN_SCALE_SHIFT_EN folds the scale into softmax and skips the SCALE op.
module attn_tile_seq #(
  parameter int SA_R      = 16,
  parameter int SA_C      = 16,
  parameter int SEQ_LEN   = 32,
  parameter int D_K       = 128,
  parameter int H_NUM     = 2,
  parameter int SCALE_VAL = 3
) (
  input  logic            I_CLK,
  input  logic            I_ASYN_RSTN,
  attn_tile_seq_if.master sif
);
  localparam int RT = SEQ_LEN / SA_R;
  localparam int CT = D_K / SA_C;
  localparam int RW = (SA_R > 1) ? $clog2(SA_R) : 1;
  localparam int HW = (H_NUM > 1) ? $clog2(H_NUM) : 1;
  localparam int TW = (RT > 1) ? $clog2(RT) : 1;
  localparam int CW = (CT > 1) ? $clog2(CT) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(SA_R - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_NUM - 1);
  localparam logic [TW-1:0] RT_LAST  = TW'(RT - 1);
  localparam logic [CW-1:0] CT_LAST  = CW'(CT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_QK_REQ, S_QK_WAIT, S_SC_REQ, S_SC_WAIT,
    S_SM_REQ, S_SM_WAIT, S_PV_REQ, S_PV_WAIT, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [HW-1:0] head, head_nx;
  logic [TW-1:0] rt, rt_nx;
  logic [RW-1:0] row, row_nx;
  logic [CW-1:0] col, col_nx;
  logic [1:0]    op_nx;
  logic          sa_req_nx, pv_nx;
  logic          start_ok, proto_hit;

  assign sif.O_SCALE_VAL = 8'(SCALE_VAL);
`ifdef ATTN_SCALE_SHIFT_EN
  assign sif.O_SM_SHIFT = 8'(SCALE_VAL);
`else
  assign sif.O_SM_SHIFT = 8'd0;
`endif

  always_comb begin
    state_nx = state;
    head_nx  = head;
    rt_nx    = rt;
    row_nx   = row;
    col_nx   = col;
    unique case (state)
      S_IDLE: if (sif.I_ATTN_START) begin
        state_nx = S_QK_REQ;
        head_nx  = '0;
        rt_nx    = '0;
        row_nx   = '0;
        col_nx   = '0;
      end
      S_QK_REQ: state_nx = S_QK_WAIT;
      S_QK_WAIT: if (sif.I_SA_VLD) begin
`ifdef ATTN_SCALE_SHIFT_EN
        state_nx = S_SM_REQ;
        row_nx   = '0;
`else
        state_nx = S_SC_REQ;
`endif
      end
      S_SC_REQ: state_nx = S_SC_WAIT;
      S_SC_WAIT: if (sif.I_SA_VLD) begin
        state_nx = S_SM_REQ;
        row_nx   = '0;
      end
      S_SM_REQ: state_nx = S_SM_WAIT;
      S_SM_WAIT: if (sif.I_SM_VLD) begin
        if (row == ROW_LAST) begin
          state_nx = S_PV_REQ;
          col_nx   = '0;
        end else begin
          state_nx = S_SM_REQ;
          row_nx   = row + RW'(1);
        end
      end
      S_PV_REQ: state_nx = S_PV_WAIT;
      S_PV_WAIT: if (sif.I_SA_VLD) begin
        if (col != CT_LAST) begin
          state_nx = S_PV_REQ;
          col_nx   = col + CW'(1);
        end else begin
          col_nx = '0;
          if (rt != RT_LAST) begin
            state_nx = S_QK_REQ;
            rt_nx    = rt + TW'(1);
          end else if (head != H_LAST) begin
            state_nx = S_QK_REQ;
            rt_nx    = '0;
            head_nx  = head + HW'(1);
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sa_req_nx = state_nx inside {S_QK_REQ, S_SC_REQ, S_PV_REQ};
    pv_nx     = state_nx inside {S_PV_REQ, S_PV_WAIT};
    unique case (1'b1)
      (state_nx inside {S_SC_REQ, S_SC_WAIT}): op_nx = 2'd1;
      pv_nx:                                   op_nx = 2'd2;
      default:                                 op_nx = 2'd0;
    endcase
  end

  // A start in S_IDLE clears the sticky error; stray valids still count.
  assign start_ok  = (state == S_IDLE) && sif.I_ATTN_START;
  assign proto_hit =
      (sif.I_SA_VLD &&
       !(state inside {S_QK_WAIT, S_SC_WAIT, S_PV_WAIT})) ||
      (sif.I_SM_VLD && (state != S_SM_WAIT)) ||
      (sif.I_ATTN_START && (state != S_IDLE));

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state             <= S_IDLE;
      head              <= '0;
      rt                <= '0;
      row               <= '0;
      col               <= '0;
      sif.O_SA_START    <= 1'b0;
      sif.O_SA_OP       <= 2'd0;
      sif.O_SM_START    <= 1'b0;
      sif.O_SM_ROW      <= '0;
      sif.O_HEAD        <= '0;
      sif.O_ROW_TILE    <= '0;
      sif.O_COL_TILE    <= '0;
      sif.O_WR_EN       <= 1'b0;
      sif.O_WR_HEAD     <= '0;
      sif.O_WR_ROW_TILE <= '0;
      sif.O_WR_COL_TILE <= '0;
      sif.O_BUSY        <= 1'b0;
      sif.O_DONE        <= 1'b0;
      sif.O_PROTO_ERR   <= 1'b0;
      sif.O_CYCLE_CNT   <= '0;
    end else begin
      state          <= state_nx;
      head           <= head_nx;
      rt             <= rt_nx;
      row            <= row_nx;
      col            <= col_nx;
      sif.O_SA_START <= sa_req_nx;
      sif.O_SA_OP    <= op_nx;
      sif.O_SM_START <= (state_nx == S_SM_REQ);
      sif.O_SM_ROW   <= row_nx;
      sif.O_HEAD     <= head_nx;
      sif.O_ROW_TILE <= rt_nx;
      sif.O_COL_TILE <= pv_nx ? col_nx : '0;
      sif.O_BUSY     <= (state_nx != S_IDLE);
      sif.O_DONE     <= (state_nx == S_DONE);
      sif.O_WR_EN    <= (state == S_PV_WAIT) && sif.I_SA_VLD;
      if ((state == S_PV_WAIT) && sif.I_SA_VLD) begin
        sif.O_WR_HEAD     <= head;
        sif.O_WR_ROW_TILE <= rt;
        sif.O_WR_COL_TILE <= col;
      end
      sif.O_PROTO_ERR <= (start_ok ? 1'b0 : sif.O_PROTO_ERR) | proto_hit;
      if (start_ok)
        sif.O_CYCLE_CNT <= '0;
      else if ((state != S_IDLE) && (sif.O_CYCLE_CNT != '1))
        sif.O_CYCLE_CNT <= sif.O_CYCLE_CNT + 32'd1;
    end
  end
endmodule

// File: tb/tb_attn_tile_seq.sv
// Scoreboard bench for attn_tile_seq: model-built op/write-back queues,
// random-latency responder, protocol-error and mid-sequence reset cases.
module tb_attn_tile_seq;
  localparam int SA_R = 16, SA_C = 16, SEQ_LEN = 32;
  localparam int D_K = 128, H_NUM = 2, SCALE_VAL = 3;
  localparam int RT = SEQ_LEN / SA_R;
  localparam int CT = D_K / SA_C;
`ifdef ATTN_SCALE_SHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  typedef struct {
    int sm; int op; int h; int r; int row; int c;
  } op_t;
  typedef struct { int h; int r; int c; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rsa = 1'b0, rsm = 1'b0, isa = 1'b0, ism = 1'b0;

  int n_cmp = 0, n_bad = 0;
  op_t exp_q[$];
  wr_t wr_q[$];
  op_t last_exp;
  int sa_cnt, sm_cnt, wr_cnt, done_cnt, busy_cyc, lat_sum;
  int exp_sa, exp_sm, exp_wr;
  int fixed_lat = 1;
  bit kill = 1'b0, mon_en = 1'b0, pv_h1 = 1'b0;
  int r_lat;
  bit r_sm, r_ab;

  attn_tile_seq_if #(
    .SA_R(SA_R), .SA_C(SA_C), .SEQ_LEN(SEQ_LEN),
    .D_K(D_K), .H_NUM(H_NUM)
  ) sif ();

  attn_tile_seq #(
    .SA_R(SA_R), .SA_C(SA_C), .SEQ_LEN(SEQ_LEN),
    .D_K(D_K), .H_NUM(H_NUM), .SCALE_VAL(SCALE_VAL)
  ) dut (
    .I_CLK(clk),
    .I_ASYN_RSTN(rst_n),
    .sif(sif)
  );

  assign sif.I_ATTN_START = start;
  assign sif.I_SA_VLD     = rsa | isa;
  assign sif.I_SM_VLD     = rsm | ism;

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act,
                     input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Reference: the loop nest written out as plain nested for-loops.
  task automatic build_model();
    op_t e;
    wr_t w;
    exp_q.delete();
    wr_q.delete();
    exp_sa = 0; exp_sm = 0; exp_wr = 0;
    for (int h = 0; h < H_NUM; h++)
      for (int r = 0; r < RT; r++) begin
        e = '{0, 0, h, r, 0, 0}; exp_q.push_back(e); exp_sa++;
        if (!SHIFT) begin
          e = '{0, 1, h, r, 0, 0}; exp_q.push_back(e); exp_sa++;
        end
        for (int k = 0; k < SA_R; k++) begin
          e = '{1, 0, h, r, k, 0}; exp_q.push_back(e); exp_sm++;
        end
        for (int c = 0; c < CT; c++) begin
          e = '{0, 2, h, r, 0, c}; exp_q.push_back(e); exp_sa++;
          w = '{h, r, c}; wr_q.push_back(w); exp_wr++;
        end
      end
  endtask

  always @(negedge clk) if (mon_en) begin
    op_t e;
    wr_t w;
    if (sif.O_BUSY) busy_cyc++;
    if (sif.O_SA_START && sif.O_SM_START) fail_now("dual_start");
    if (sif.O_SA_START || sif.O_SM_START) begin
      if (sif.O_SM_START) sm_cnt++; else sa_cnt++;
      if (exp_q.size() == 0) fail_now("extra_start");
      else begin
        e = exp_q.pop_front();
        last_exp = e;
        chk("start_kind", sif.O_SM_START, e.sm);
        chk("head", sif.O_HEAD, e.h);
        chk("row_tile", sif.O_ROW_TILE, e.r);
        chk("col_tile", sif.O_COL_TILE, e.c);
        if (e.sm != 0) chk("sm_row", sif.O_SM_ROW, e.row);
        else chk("sa_op", sif.O_SA_OP, e.op);
        if (e.sm == 0 && e.op == 2 && e.h == 1) pv_h1 = 1'b1;
      end
    end
    if (sif.O_WR_EN) begin
      wr_cnt++;
      if (wr_q.size() == 0) fail_now("extra_wr");
      else begin
        w = wr_q.pop_front();
        chk("wr_head", sif.O_WR_HEAD, w.h);
        chk("wr_row_tile", sif.O_WR_ROW_TILE, w.r);
        chk("wr_col_tile", sif.O_WR_COL_TILE, w.c);
      end
    end
    if (sif.O_DONE) begin
      done_cnt++;
      chk("done_cycle", busy_cyc, lat_sum + 1);
    end
  end

  // Responder: answers each start after 1..6 cycles, checks coords held.
  initial forever begin
    @(negedge clk);
    if (mon_en && !kill && (sif.O_SA_START || sif.O_SM_START)) begin
      r_sm = sif.O_SM_START;
      r_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
      lat_sum += 1 + r_lat;
      r_ab = 1'b0;
      for (int i = 0; i < r_lat; i++) begin
        @(posedge clk);
        if (kill) r_ab = 1'b1;
      end
      if (!r_ab) begin
        #1;
        chk("hold_head", sif.O_HEAD, last_exp.h);
        chk("hold_row_tile", sif.O_ROW_TILE, last_exp.r);
        if (r_sm) chk("hold_sm_row", sif.O_SM_ROW, last_exp.row);
        else chk("hold_col_tile", sif.O_COL_TILE, last_exp.c);
        if (r_sm) rsm = 1'b1; else rsa = 1'b1;
        @(posedge clk);
        #1;
        rsa = 1'b0;
        rsm = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic begin_run(input int lat);
    lat_sum = 0; busy_cyc = 0; done_cnt = 0;
    sa_cnt = 0; sm_cnt = 0; wr_cnt = 0;
    build_model();
    fixed_lat = lat;
    pv_h1 = 1'b0;
    mon_en = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("start_sa_pulse", sif.O_SA_START, 1);
    chk("start_busy", sif.O_BUSY, 1);
    chk("start_perr_clr", sif.O_PROTO_ERR, 0);
  endtask

  task automatic run_seq(input int lat, input bit inject);
    int t;
    begin_run(lat);
    if (inject) begin
      @(posedge clk); #1 ism = 1'b1;
      @(posedge clk); #1 ism = 1'b0;
      @(negedge clk);
      chk("perr_sm_in_qk", sif.O_PROTO_ERR, 1);
      repeat (20) @(posedge clk);
      pulse_start();
    end
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) fail_now("done_timeout");
    @(negedge clk);
    chk("cycle_cnt", sif.O_CYCLE_CNT, lat_sum + 1);
    chk("idle_busy", sif.O_BUSY, 0);
    chk("sa_starts", sa_cnt, exp_sa);
    chk("sm_starts", sm_cnt, exp_sm);
    chk("wr_pulses", wr_cnt, exp_wr);
    chk("done_pulses", done_cnt, 1);
    chk("ops_left", exp_q.size(), 0);
    chk("perr_end", sif.O_PROTO_ERR, inject);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, sif.O_BUSY, 0);
    chk({tag, "_sa_start"}, sif.O_SA_START, 0);
    chk({tag, "_sm_start"}, sif.O_SM_START, 0);
    chk({tag, "_sa_op"}, sif.O_SA_OP, 0);
    chk({tag, "_head"}, sif.O_HEAD, 0);
    chk({tag, "_row_tile"}, sif.O_ROW_TILE, 0);
    chk({tag, "_col_tile"}, sif.O_COL_TILE, 0);
    chk({tag, "_sm_row"}, sif.O_SM_ROW, 0);
    chk({tag, "_wr_en"}, sif.O_WR_EN, 0);
    chk({tag, "_done"}, sif.O_DONE, 0);
    chk({tag, "_perr"}, sif.O_PROTO_ERR, 0);
    chk({tag, "_cnt"}, sif.O_CYCLE_CNT, 0);
    chk({tag, "_scale"}, sif.O_SCALE_VAL, SCALE_VAL);
    chk({tag, "_shift"}, sif.O_SM_SHIFT, SHIFT ? SCALE_VAL : 0);
  endtask

  task automatic reset_mid();
    int t;
    begin_run(5);
    t = 0;
    while (!pv_h1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!pv_h1) fail_now("pv_h1_timeout");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    kill = 1'b1;
    mon_en = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    kill = 1'b0;
    @(posedge clk); #1 isa = 1'b1;
    @(posedge clk); #1 isa = 1'b0;
    @(negedge clk);
    chk("perr_stray_sa", sif.O_PROTO_ERR, 1);
    chk("stray_busy", sif.O_BUSY, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_rst");
    run_seq(1, 1'b0);
    run_seq(0, 1'b0);
    run_seq(3, 1'b1);
    run_seq(2, 1'b0);
    reset_mid();
    run_seq(0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
